// File: rtl/ddr_arbiter.sv
// Two-port round-robin arbiter in front of the DDRAM Avalon-MM burst port.
// Grants whole bursts and steers read beats back to the burst owner.
module ddr_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 64,
    parameter int BURST_WIDTH = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in0_rd,
    input  logic                    in0_wr,
    input  logic [ADDR_WIDTH-1:0]   in0_addr,
    input  logic [BURST_WIDTH-1:0]  in0_burstLength,
    input  logic [DATA_WIDTH/8-1:0] in0_mask,
    input  logic [DATA_WIDTH-1:0]   in0_din,
    output logic                    in0_waitReq,
    output logic                    in0_valid,
    output logic [DATA_WIDTH-1:0]   in0_dout,
    input  logic                    in1_rd,
    input  logic                    in1_wr,
    input  logic [ADDR_WIDTH-1:0]   in1_addr,
    input  logic [BURST_WIDTH-1:0]  in1_burstLength,
    input  logic [DATA_WIDTH/8-1:0] in1_mask,
    input  logic [DATA_WIDTH-1:0]   in1_din,
    output logic                    in1_waitReq,
    output logic                    in1_valid,
    output logic [DATA_WIDTH-1:0]   in1_dout,
    output logic                    ddr_rd,
    output logic                    ddr_wr,
    output logic [ADDR_WIDTH-1:0]   ddr_addr,
    output logic [BURST_WIDTH-1:0]  ddr_burstLength,
    output logic [DATA_WIDTH/8-1:0] ddr_mask,
    output logic [DATA_WIDTH-1:0]   ddr_din,
    input  logic                    ddr_waitReq,
    input  logic                    ddr_valid,
    input  logic [DATA_WIDTH-1:0]   ddr_dout
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] READ_CMD  = 2'd1;
    localparam logic [1:0] READ_DATA = 2'd2;
    localparam logic [1:0] WRITE     = 2'd3;

    logic [1:0]             state;
    logic                   owner;
    logic                   prio;
    logic [BURST_WIDTH-1:0] count;
    logic [BURST_WIDTH-1:0] len;
    logic [BURST_WIDTH-1:0] count_nxt;

    logic                   req0;
    logic                   req1;
    logic                   grant;
    logic                   grant_wr;
    logic [BURST_WIDTH-1:0] grant_bl;

    logic                   own_rd;
    logic                   own_wr;
    logic                   stall;
    logic                   beat;

    assign req0      = in0_rd | in0_wr;
    assign req1      = in1_rd | in1_wr;
    assign grant     = (req0 & req1) ? prio : req1;
    assign grant_wr  = grant ? in1_wr : in0_wr;
    assign grant_bl  = grant ? in1_burstLength : in0_burstLength;
    assign own_rd    = owner ? in1_rd : in0_rd;
    assign own_wr    = owner ? in1_wr : in0_wr;
    assign count_nxt = count + 1'b1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            owner <= 1'b0;
            prio  <= 1'b0;
            count <= '0;
            len   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        owner <= grant;
                        count <= '0;
                        // A zero-length burst is still one beat on the bus
                        len   <= (grant_bl == '0) ? BURST_WIDTH'(1) : grant_bl;
                        state <= grant_wr ? WRITE : READ_CMD;
                    end
                end
                READ_CMD: begin
                    if (own_rd && !ddr_waitReq) begin
                        state <= READ_DATA;
                        count <= '0;
                    end else if (!own_rd) begin
                        state <= IDLE;
                    end
                end
                READ_DATA: begin
                    if (ddr_valid) begin
                        count <= count_nxt;
                        if (count_nxt == len) begin
                            state <= IDLE;
                            prio  <= ~owner;
                        end
                    end
                end
                default: begin
                    if (own_wr && !ddr_waitReq) begin
                        count <= count_nxt;
                        if (count_nxt == len) begin
                            state <= IDLE;
                            prio  <= ~owner;
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        ddr_rd          = (state == READ_CMD) & own_rd;
        ddr_wr          = (state == WRITE) & own_wr;
        ddr_addr        = owner ? in1_addr : in0_addr;
        ddr_burstLength = owner ? in1_burstLength : in0_burstLength;
        ddr_mask        = owner ? in1_mask : in0_mask;
        ddr_din         = owner ? in1_din : in0_din;
    end

    // Beats outside READ_DATA (stale reads) never reach a requester
    assign stall = (state == READ_CMD || state == WRITE) ? ddr_waitReq : 1'b1;
    assign beat  = (state == READ_DATA) & ddr_valid;

    assign in0_waitReq = owner ? 1'b1 : stall;
    assign in1_waitReq = owner ? stall : 1'b1;
    assign in0_valid   = beat & ~owner;
    assign in1_valid   = beat & owner;
    assign in0_dout    = ddr_dout;
    assign in1_dout    = ddr_dout;

endmodule
